// File: rtl/rtc_load_sched_if.sv
// Command request channel from one requester (host register block or PTP servo)
// into rtc_load_sched.
//   valid : command valid
//   ready : command accepted when valid & ready
//   op    : 0 TIME, 1 PERIOD, 2 ADJ, 3 OFFSET
//   data  : payload; each load bus takes the LSBs it needs
// The requester uses the master modport and the scheduler uses the slave modport.
interface rtc_load_sched_if #(
    parameter int unsigned DATA_W = 72
) ();
    logic              valid;
    logic              ready;
    logic [1:0]        op;
    logic [DATA_W-1:0] data;

    modport master (
        output valid,
        output op,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  op,
        input  data,
        output ready
    );
endinterface

// File: rtl/rtc_load_sched.sv
// rtc_load_sched: sequencer and arbiter in front of the rtc_mini load ports.
// Two requesters share the RTC: host (register block) and srv (PTP servo). The block grants
// one command at a time and drives the matching single-cycle load strobe plus data. An ADJ
// command is held until rtc_mini returns adj_ld_done or the timeout expires. Every load is
// followed by GUARD_CYC idle cycles before the next grant.
// Ports:
//   clk, rst          shared clock with rtc_mini; synchronous active-high reset
//   host, srv         request channels (slave side of rtc_load_sched_if)
//   time_ld           strobe, time_reg_ns_in = data[71:0]
//   period_ld         strobe, period_in = data[PERIOD_W-1:0]
//   adj_ld            strobe, adj_ld_data = data
//   adj_ld_done       pulse from rtc_mini: adjustment consumed
//   offset_ld         strobe, offset_ptp_ns_in = data[OFFSET_W-1:0]
//   busy              scheduler not idle
//   done              pulse: command completed
//   done_src          requester of the completed/aborted command (0 host, 1 srv)
//   adj_timeout       pulse: ADJ aborted because adj_ld_done never arrived
// DATA_W must be at least 72 since the time bus is 72 bits wide.
module rtc_load_sched #(
    parameter int unsigned DATA_W      = 72,
    parameter int unsigned PERIOD_W    = 40,
    parameter int unsigned OFFSET_W    = 64,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned GUARD_CYC   = 2
) (
    input  logic                clk,
    input  logic                rst,
    rtc_load_sched_if.slave     host,
    rtc_load_sched_if.slave     srv,
    output logic                time_ld,
    output logic [71:0]         time_reg_ns_in,
    output logic                period_ld,
    output logic [PERIOD_W-1:0] period_in,
    output logic                adj_ld,
    output logic [DATA_W-1:0]   adj_ld_data,
    input  logic                adj_ld_done,
    output logic                offset_ld,
    output logic [OFFSET_W-1:0] offset_ptp_ns_in,
    output logic                busy,
    output logic                done,
    output logic                done_src,
    output logic                adj_timeout
);

    typedef enum logic [1:0] {
        OpTime   = 2'd0,
        OpPeriod = 2'd1,
        OpAdj    = 2'd2,
        OpOffset = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StIssue   = 2'd1,
        StWaitAdj = 2'd2,
        StGuard   = 2'd3
    } state_e;

    localparam int unsigned TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned GRD_W = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam logic [TMR_W-1:0] TmrLast = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [GRD_W-1:0] GrdLast = GRD_W'(GUARD_CYC - 1);
    localparam bit TmoEnable = (TIMEOUT_CYC != 0);

    state_e              state_q, state_d;
    op_e                 op_q;
    logic                src_q;
    logic                last_srv_q;     // 1: servo was granted most recently
    logic [TMR_W-1:0]    tmr_q;
    logic [GRD_W-1:0]    grd_q;
    logic                adj_done_q;     // delayed adj_ld_done, becomes the done pulse
    logic [71:0]         time_q;
    logic [PERIOD_W-1:0] period_q;
    logic [DATA_W-1:0]   adj_q;
    logic [OFFSET_W-1:0] offset_q;

    logic                grant_srv;
    logic                host_acc;
    logic                srv_acc;
    logic                accept;
    op_e                 sel_op;
    logic [DATA_W-1:0]   sel_data;
    logic                tmo_hit;

    // Grant is purely combinational from the valids; round-robin only matters when both
    // requesters want the bus in the same idle cycle.
    always_comb begin
        grant_srv = 1'b0;
        if (host.valid && srv.valid) begin
            grant_srv = ~last_srv_q;
        end else begin
            grant_srv = srv.valid;
        end
    end

    assign host_acc   = (state_q == StIdle) && !rst && host.valid && !grant_srv;
    assign srv_acc    = (state_q == StIdle) && !rst && srv.valid && grant_srv;
    assign accept     = host_acc || srv_acc;
    assign host.ready = host_acc;
    assign srv.ready  = srv_acc;

    assign sel_op   = grant_srv ? op_e'(srv.op) : op_e'(host.op);
    assign sel_data = grant_srv ? srv.data : host.data;

    assign tmo_hit = TmoEnable && (tmr_q == TmrLast);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = (op_q == OpAdj) ? StWaitAdj : StGuard;
            end
            StWaitAdj: begin
                // adj_ld_done is tested first so it wins over a same-cycle timeout
                if (adj_ld_done) begin
                    state_d = StGuard;
                end else if (tmo_hit) begin
                    state_d = StGuard;
                end
            end
            StGuard: begin
                if (grd_q == GrdLast) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath: latched command, load buses, timers
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= OpTime;
            src_q      <= 1'b0;
            last_srv_q <= 1'b1;
            tmr_q      <= '0;
            grd_q      <= '0;
            adj_done_q <= 1'b0;
            time_q     <= '0;
            period_q   <= '0;
            adj_q      <= '0;
            offset_q   <= '0;
        end else begin
            if (accept) begin
                op_q       <= sel_op;
                src_q      <= grant_srv;
                last_srv_q <= grant_srv;
                // Buses change only on their own load and hold until the next one
                unique case (sel_op)
                    OpTime:   time_q   <= sel_data[71:0];
                    OpPeriod: period_q <= sel_data[PERIOD_W-1:0];
                    OpAdj:    adj_q    <= sel_data;
                    OpOffset: offset_q <= sel_data[OFFSET_W-1:0];
                    default:  ;
                endcase
            end

            if (state_q == StIssue) begin
                tmr_q <= '0;
            end else if (state_q == StWaitAdj && TmoEnable) begin
                tmr_q <= tmr_q + 1'b1;
            end

            if (state_q == StGuard) begin
                grd_q <= grd_q + 1'b1;
            end else begin
                grd_q <= '0;
            end

            adj_done_q <= (state_q == StWaitAdj) && adj_ld_done;
        end
    end

    // Outputs; pulses are masked during rst so an aborted command reports nothing
    always_comb begin
        time_ld     = 1'b0;
        period_ld   = 1'b0;
        adj_ld      = 1'b0;
        offset_ld   = 1'b0;
        done        = 1'b0;
        adj_timeout = 1'b0;
        if (!rst) begin
            if (state_q == StIssue) begin
                time_ld   = (op_q == OpTime);
                period_ld = (op_q == OpPeriod);
                adj_ld    = (op_q == OpAdj);
                offset_ld = (op_q == OpOffset);
            end
            done        = ((state_q == StIssue) && (op_q != OpAdj)) || adj_done_q;
            adj_timeout = (state_q == StWaitAdj) && tmo_hit && !adj_ld_done;
        end
        done_src         = (done || adj_timeout) && src_q;
        busy             = (state_q != StIdle);
        time_reg_ns_in   = time_q;
        period_in        = period_q;
        adj_ld_data      = adj_q;
        offset_ptp_ns_in = offset_q;
    end

endmodule

// File: tb/tb_rtc_load_sched.sv
module tb_rtc_load_sched;
    localparam int unsigned DW = 72;
    localparam int unsigned PW = 40;
    localparam int unsigned OW = 64;
    localparam int unsigned TO = 16;
    localparam int unsigned GC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          adj_ld_done;
    logic          time_ld, period_ld, adj_ld, offset_ld;
    logic [71:0]   time_reg_ns_in;
    logic [PW-1:0] period_in;
    logic [DW-1:0] adj_ld_data;
    logic [OW-1:0] offset_ptp_ns_in;
    logic          busy, done, done_src, adj_timeout;

    always #5 clk = ~clk;

    rtc_load_sched_if #(.DATA_W(DW)) host_if ();
    rtc_load_sched_if #(.DATA_W(DW)) srv_if ();

    rtc_load_sched #(
        .DATA_W(DW), .PERIOD_W(PW), .OFFSET_W(OW), .TIMEOUT_CYC(TO), .GUARD_CYC(GC)
    ) dut (
        .clk(clk), .rst(rst), .host(host_if), .srv(srv_if),
        .time_ld(time_ld), .time_reg_ns_in(time_reg_ns_in),
        .period_ld(period_ld), .period_in(period_in),
        .adj_ld(adj_ld), .adj_ld_data(adj_ld_data), .adj_ld_done(adj_ld_done),
        .offset_ld(offset_ld), .offset_ptp_ns_in(offset_ptp_ns_in),
        .busy(busy), .done(done), .done_src(done_src), .adj_timeout(adj_timeout)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pos();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    function automatic logic [3:0] stb();
        return {time_ld, period_ld, adj_ld, offset_ld};
    endfunction

    function automatic logic [71:0] bus_val(input logic [1:0] op);
        case (op)
            2'd0:    return time_reg_ns_in;
            2'd1:    return {32'd0, period_in};
            2'd2:    return adj_ld_data;
            default: return {8'd0, offset_ptp_ns_in};
        endcase
    endfunction

    task automatic drive(input logic src, input logic v, input logic [1:0] op,
                         input logic [71:0] d);
        if (src) begin
            srv_if.valid = v; srv_if.op = op; srv_if.data = d;
        end else begin
            host_if.valid = v; host_if.op = op; host_if.data = d;
        end
    endtask

    task automatic do_reset();
        pos();
        rst = 1'b1;
        host_if.valid = 1'b0;
        srv_if.valid = 1'b0;
        adj_ld_done = 1'b0;
        pos();
        rst = 1'b0;
        neg();
    endtask

    typedef struct {
        logic        src;
        logic [1:0]  op;
        logic [71:0] data;
        logic [3:0]  exp_stb;
        logic [71:0] exp_val;
    } vec_t;

    vec_t vecs[6];

    // Stream stimulus and expected strobe log
    logic [1:0]  h_op[4];
    logic [71:0] h_dat[4];
    logic [1:0]  s_op[4];
    logic [71:0] s_dat[4];
    int          h_n, s_n;
    logic        e_src[8];
    logic [1:0]  e_op[8];
    logic [3:0]  e_stb[8];
    logic [71:0] e_val[8];
    int          e_n;

    task automatic run_stream(input string tag);
        int hi = 0;
        int si = 0;
        int nlog = 0;
        int cyc = 0;
        int last = 0;
        int multi = 0;
        int extra = 0;
        logic h_acc, s_acc;
        pos();
        drive(1'b0, h_n > 0, h_op[0], h_dat[0]);
        drive(1'b1, s_n > 0, s_op[0], s_dat[0]);
        while (nlog < e_n && cyc < 200) begin
            neg();
            h_acc = host_if.valid & host_if.ready;
            s_acc = srv_if.valid & srv_if.ready;
            if ($countones(stb()) > 1) multi++;
            if (stb() != 4'd0) begin
                chk({tag, "_stb"}, stb(), e_stb[nlog]);
                chk({tag, "_val"}, bus_val(e_op[nlog]), e_val[nlog]);
                chk({tag, "_done"}, done, 1'b1);
                chk({tag, "_src"}, done_src, e_src[nlog]);
                if (nlog > 0) chk({tag, "_spacing"}, cyc - last, 2 + GC);
                last = cyc;
                nlog++;
            end
            pos();
            cyc++;
            if (h_acc) begin
                hi++;
                if (hi < h_n) drive(1'b0, 1'b1, h_op[hi], h_dat[hi]);
                else host_if.valid = 1'b0;
            end
            if (s_acc) begin
                si++;
                if (si < s_n) drive(1'b1, 1'b1, s_op[si], s_dat[si]);
                else srv_if.valid = 1'b0;
            end
        end
        chk({tag, "_count"}, nlog, e_n);
        for (int k = 0; k < 10; k++) begin
            neg();
            if (stb() != 4'd0) extra++;
            if ($countones(stb()) > 1) multi++;
            pos();
        end
        chk({tag, "_no_dup"}, extra, 0);
        chk({tag, "_one_strobe"}, multi, 0);
        host_if.valid = 1'b0;
        srv_if.valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int to_cnt, to_at, dn_cnt;
        logic to_src;

        vecs[0] = '{1'b0, 2'd0, 72'h12_3456_789A_BCDE_F012, 4'b1000, 72'h12_3456_789A_BCDE_F012};
        vecs[1] = '{1'b1, 2'd1, 72'hFF_AAAA_BBBB_CCCC_DDDD, 4'b0100, 72'h00_0000_00BB_CCCC_DDDD};
        vecs[2] = '{1'b0, 2'd3, 72'hAB_1122_3344_5566_7788, 4'b0001, 72'h00_1122_3344_5566_7788};
        vecs[3] = '{1'b1, 2'd0, 72'hFE_DCBA_9876_5432_10AA, 4'b1000, 72'hFE_DCBA_9876_5432_10AA};
        vecs[4] = '{1'b0, 2'd1, 72'h00_0000_0012_3456_789A, 4'b0100, 72'h00_0000_0012_3456_789A};
        vecs[5] = '{1'b1, 2'd3, 72'h55_FFFF_FFFF_FFFF_FFFF, 4'b0001, 72'h00_FFFF_FFFF_FFFF_FFFF};

        rst = 1'b1;
        adj_ld_done = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 72'd0);
        drive(1'b1, 1'b0, 2'd0, 72'd0);
        pos();
        pos();
        neg();
        chk("rst_stb", stb(), 4'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_done_src", done_src, 1'b0);
        chk("rst_timeout", adj_timeout, 1'b0);
        chk("rst_time_bus", time_reg_ns_in, 72'd0);
        chk("rst_adj_bus", adj_ld_data, 72'd0);
        pos();
        rst = 1'b0;
        neg();

        // Single non-ADJ commands
        for (int i = 0; i < 6; i++) begin
            pos();
            drive(vecs[i].src, 1'b1, vecs[i].op, vecs[i].data);
            neg();
            chk("vec_ready", vecs[i].src ? srv_if.ready : host_if.ready, 1'b1);
            chk("vec_other_ready", vecs[i].src ? host_if.ready : srv_if.ready, 1'b0);
            chk("vec_idle_busy", busy, 1'b0);
            pos();
            drive(vecs[i].src, 1'b0, vecs[i].op, ~vecs[i].data);
            neg();
            chk("vec_stb", stb(), vecs[i].exp_stb);
            chk("vec_val", bus_val(vecs[i].op), vecs[i].exp_val);
            chk("vec_done", done, 1'b1);
            chk("vec_done_src", done_src, vecs[i].src);
            chk("vec_timeout", adj_timeout, 1'b0);
            for (int g = 0; g < GC; g++) begin
                pos();
                neg();
                chk("vec_guard_stb", stb(), 4'd0);
                chk("vec_guard_busy", busy, 1'b1);
            end
            pos();
            neg();
            chk("vec_back_idle", busy, 1'b0);
            chk("vec_hold", bus_val(vecs[i].op), vecs[i].exp_val);
        end

        // Host ADJ acknowledged 5 cycles after adj_ld
        pos();
        drive(1'b0, 1'b1, 2'd2, 72'hDE_ADBE_EF01_2345_6789);
        neg();
        chk("adj_ready", host_if.ready, 1'b1);
        pos();
        host_if.valid = 1'b0;
        neg();
        chk("adj_stb", stb(), 4'b0010);
        chk("adj_data", adj_ld_data, 72'hDE_ADBE_EF01_2345_6789);
        chk("adj_no_early_done", done, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            pos();
            neg();
            chk("adj_wait_busy", busy, 1'b1);
            chk("adj_wait_done", {done, adj_timeout}, 2'b00);
        end
        pos();
        adj_ld_done = 1'b1;
        neg();
        chk("adj_ack_cycle_done", done, 1'b0);
        pos();
        adj_ld_done = 1'b0;
        neg();
        chk("adj_done", done, 1'b1);
        chk("adj_done_src", done_src, 1'b0);
        chk("adj_no_timeout", adj_timeout, 1'b0);
        chk("adj_guard_busy", busy, 1'b1);
        pos();
        neg();
        chk("adj_done_once", done, 1'b0);
        chk("adj_guard2_busy", busy, 1'b1);
        pos();
        neg();
        chk("adj_idle", busy, 1'b0);

        // Servo ADJ never acknowledged
        pos();
        drive(1'b1, 1'b1, 2'd2, 72'h01_0203_0405_0607_0809);
        neg();
        chk("tmo_ready", srv_if.ready, 1'b1);
        pos();
        srv_if.valid = 1'b0;
        neg();
        chk("tmo_stb", stb(), 4'b0010);
        to_cnt = 0;
        to_at = -1;
        dn_cnt = 0;
        to_src = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            pos();
            neg();
            if (adj_timeout) begin
                to_cnt++;
                to_at = k;
                to_src = done_src;
            end
            if (done) dn_cnt++;
            if (k == 18) chk("tmo_guard_busy", busy, 1'b1);
            if (k == 19) chk("tmo_idle", busy, 1'b0);
        end
        chk("tmo_count", to_cnt, 1);
        chk("tmo_latency", to_at, TO);
        chk("tmo_src", to_src, 1'b1);
        chk("tmo_no_done", dn_cnt, 0);

        // Reset while waiting for adj_ld_done
        pos();
        drive(1'b0, 1'b1, 2'd2, 72'h77_6655_4433_2211_0099);
        neg();
        pos();
        host_if.valid = 1'b0;
        neg();
        chk("rstw_stb", stb(), 4'b0010);
        pos();
        neg();
        pos();
        neg();
        pos();
        rst = 1'b1;
        neg();
        chk("rstw_no_pulse", {done, adj_timeout}, 2'b00);
        pos();
        rst = 1'b0;
        neg();
        chk("rstw_stb0", stb(), 4'd0);
        chk("rstw_busy", busy, 1'b0);
        chk("rstw_flags", {done, done_src, adj_timeout}, 3'b000);
        chk("rstw_time_bus", time_reg_ns_in, 72'd0);
        chk("rstw_period_bus", period_in, 40'd0);
        chk("rstw_adj_bus", adj_ld_data, 72'd0);
        chk("rstw_offset_bus", offset_ptp_ns_in, 64'd0);
        pos();
        adj_ld_done = 1'b1;
        neg();
        chk("stray_ack_busy", busy, 1'b0);
        pos();
        adj_ld_done = 1'b0;
        neg();
        chk("stray_ack_flags", {done, adj_timeout, busy}, 3'b000);

        // Both valid straight out of reset: host first
        h_n = 1; s_n = 1; e_n = 2;
        h_op[0] = 2'd1; h_dat[0] = 72'h00_0000_0008_0000_0000;
        s_op[0] = 2'd3; s_dat[0] = 72'd500;
        e_src[0] = 1'b0; e_op[0] = 2'd1; e_stb[0] = 4'b0100; e_val[0] = 72'h00_0000_0008_0000_0000;
        e_src[1] = 1'b1; e_op[1] = 2'd3; e_stb[1] = 4'b0001; e_val[1] = 72'd500;
        run_stream("both");

        // Both streaming 4 commands each
        do_reset();
        h_n = 4; s_n = 4; e_n = 8;
        h_op[0] = 2'd0; h_dat[0] = 72'hA0_0000_0000_0000_0001;
        h_op[1] = 2'd1; h_dat[1] = 72'hA1_0000_00C0_0000_0003;
        h_op[2] = 2'd3; h_dat[2] = 72'hA2_0000_0000_0000_0005;
        h_op[3] = 2'd0; h_dat[3] = 72'hA3_0000_0000_0000_0007;
        s_op[0] = 2'd3; s_dat[0] = 72'hB0_0000_0000_0000_0002;
        s_op[1] = 2'd0; s_dat[1] = 72'hB1_0000_0000_0000_0004;
        s_op[2] = 2'd1; s_dat[2] = 72'hB2_0000_0000_0000_0006;
        s_op[3] = 2'd3; s_dat[3] = 72'hB3_0000_0000_0000_0008;
        e_src[0] = 1'b0; e_op[0] = 2'd0; e_stb[0] = 4'b1000; e_val[0] = 72'hA0_0000_0000_0000_0001;
        e_src[1] = 1'b1; e_op[1] = 2'd3; e_stb[1] = 4'b0001; e_val[1] = 72'h2;
        e_src[2] = 1'b0; e_op[2] = 2'd1; e_stb[2] = 4'b0100; e_val[2] = 72'h00_0000_00C0_0000_0003;
        e_src[3] = 1'b1; e_op[3] = 2'd0; e_stb[3] = 4'b1000; e_val[3] = 72'hB1_0000_0000_0000_0004;
        e_src[4] = 1'b0; e_op[4] = 2'd3; e_stb[4] = 4'b0001; e_val[4] = 72'h5;
        e_src[5] = 1'b1; e_op[5] = 2'd1; e_stb[5] = 4'b0100; e_val[5] = 72'h6;
        e_src[6] = 1'b0; e_op[6] = 2'd0; e_stb[6] = 4'b1000; e_val[6] = 72'hA3_0000_0000_0000_0007;
        e_src[7] = 1'b1; e_op[7] = 2'd3; e_stb[7] = 4'b0001; e_val[7] = 72'h8;
        run_stream("stream");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
